// File: rtl/mul_div_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M mul/div unit.
// The master side issues operations; the slave side returns a write-back request.
interface mul_div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] Operand1;
    logic [XLEN-1:0] Operand2;
    logic [4:0]      DestAddr;
    logic            Kill;
    logic            Busy;
    logic            Done;
    logic            RegWrite;
    logic [4:0]      WriteAddr;
    logic [XLEN-1:0] WriteData;

    modport master (
        output Start, Funct3, Operand1, Operand2, DestAddr, Kill,
        input  Busy, Done, RegWrite, WriteAddr, WriteData
    );

    modport slave (
        input  Start, Funct3, Operand1, Operand2, DestAddr, Kill,
        output Busy, Done, RegWrite, WriteAddr, WriteData
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign fix-up folded into the last step.
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_regwrite;
    logic [4:0]        r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quot;

    // Accept-side decode: operand signedness, magnitudes, result sign and fast path
    logic              w_sgn1;
    logic              w_sgn2;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_neg_flag;
    logic              w_is_div;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;

    always_comb begin
        w_sgn1     = 1'b0;
        w_sgn2     = 1'b0;
        unique case (bus.Funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sgn1 = 1'b1;
                w_sgn2 = 1'b1;
            end
            3'b010:  w_sgn1 = 1'b1;
            default: ;
        endcase
        w_neg1     = w_sgn1 && bus.Operand1[XLEN-1];
        w_neg2     = w_sgn2 && bus.Operand2[XLEN-1];
        w_abs1     = w_neg1 ? -bus.Operand1 : bus.Operand1;
        w_abs2     = w_neg2 ? -bus.Operand2 : bus.Operand2;
        // REM keeps the dividend's sign; every other signed op negates on sign mismatch
        w_neg_flag = (bus.Funct3 == 3'b110) ? w_neg1 : (w_neg1 ^ w_neg2);
        w_is_div   = bus.Funct3[2];
        w_div0     = w_is_div && (bus.Operand2 == '0);
        w_ovf      = w_is_div && !bus.Funct3[0] && (bus.Operand1 == MIN_NEG) && (bus.Operand2 == '1);
        w_fast     = w_div0 || w_ovf;
        if (bus.Funct3[1])
            w_fast_res = w_div0 ? bus.Operand1 : '0;
        else
            w_fast_res = w_div0 ? '1 : MIN_NEG;
    end

    // One iteration of each datapath; the FSM picks which registers consume it
    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN+1:0]   w_shift;
    logic              w_qbit;
    logic [XLEN:0]     w_rem_next;
    logic [XLEN-1:0]   w_quot_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_qfix;
    logic [XLEN-1:0]   w_rfix;
    logic [XLEN-1:0]   w_result;

    always_comb begin
        w_add       = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_acc_next  = {w_add, r_acc[XLEN-1:1]};
        w_shift     = {r_rem, r_quot[XLEN-1]};
        w_qbit      = (w_shift >= (XLEN+2)'(r_opb));
        w_rem_next  = w_qbit ? (XLEN+1)'(w_shift - (XLEN+2)'(r_opb)) : (XLEN+1)'(w_shift);
        w_quot_next = {r_quot[XLEN-2:0], w_qbit};
        w_prod      = r_neg ? -w_acc_next : w_acc_next;
        w_qfix      = r_neg ? -w_quot_next : w_quot_next;
        w_rfix      = r_neg ? -w_rem_next[XLEN-1:0] : w_rem_next[XLEN-1:0];
        unique case (r_funct3)
            3'b000:                 w_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_result = w_qfix;
            default:                w_result = w_rfix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_neg      <= 1'b0;
            r_count    <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
        end else if (bus.Kill) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done     <= 1'b0;
                    r_regwrite <= 1'b0;
                    if (bus.Start) begin
                        r_busy   <= 1'b1;
                        r_rd     <= bus.DestAddr;
                        r_funct3 <= bus.Funct3;
                        r_neg    <= w_neg_flag;
                        r_count  <= '0;
                        r_opb    <= w_is_div ? w_abs2 : w_abs1;
                        r_acc    <= {{XLEN{1'b0}}, w_abs2};
                        r_rem    <= '0;
                        r_quot   <= w_abs1;
                        if (w_fast) begin
                            r_wdata <= w_fast_res;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_next;
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(XLEN - 1)) begin
                        r_wdata <= w_result;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle raises the write-back; the second releases the unit
                    if (!r_done) begin
                        r_done     <= 1'b1;
                        r_regwrite <= (r_rd != '0);
                        r_waddr    <= r_rd;
                    end else begin
                        r_done     <= 1'b0;
                        r_regwrite <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.RegWrite  = r_regwrite;
    assign bus.WriteAddr = r_waddr;
    assign bus.WriteData = r_wdata;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected write-backs are queued at issue and
// compared (data, address, enable, latency) when Done is observed.
module tb_mul_div_unit;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        rw;
        int unsigned acc_cyc;
        int unsigned lat;
    } exp_t;

    exp_t q_exp[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sbv; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub;  return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sbv; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Monitor: compares every Done against the head of the scoreboard
    logic prev_done;
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done)
                check_eq("busy_after_done", {31'b0, bus.Busy}, 32'd0);
            if (bus.Done) begin
                if (q_exp.size() == 0) begin
                    check_eq("unexpected_done", {31'b0, bus.Done}, 32'd0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check_eq({e.tag, "_data"}, bus.WriteData, e.data);
                    check_eq({e.tag, "_addr"}, {27'b0, bus.WriteAddr}, {27'b0, e.addr});
                    check_eq({e.tag, "_rw"}, {31'b0, bus.RegWrite}, {31'b0, e.rw});
                    check_eq({e.tag, "_lat"}, cyc - e.acc_cyc, e.lat);
                end
            end
            prev_done = bus.Done;
        end
    end

    // Called at a negedge; drives one Start pulse and optionally queues the expected result
    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit push,
                         input logic [31:0] exp, input int unsigned lat);
        exp_t e;
        bus.Start    = 1'b1;
        bus.Funct3   = f3;
        bus.Operand1 = a;
        bus.Operand2 = b;
        bus.DestAddr = rd;
        @(posedge clk);
        #1;
        if (push) begin
            e.tag = tag; e.data = exp; e.addr = rd; e.rw = (rd != 0);
            e.acc_cyc = cyc; e.lat = lat;
            q_exp.push_back(e);
        end
        @(negedge clk);
        bus.Start    = 1'b0;
        bus.Funct3   = 3'($urandom);
        bus.Operand1 = $urandom;
        bus.Operand2 = $urandom;
        bus.DestAddr = 5'($urandom);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (q_exp.size() == 0 && !bus.Busy && !prev_done) break;
            @(negedge clk);
        end
        check_eq({tag, "_drain"}, q_exp.size(), 32'd0);
        q_exp.delete();
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int unsigned lat);
        issue(tag, f3, a, b, rd, 1'b1, exp, lat);
        drain(tag);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        bus.Start = 1'b0; bus.Kill = 1'b0; bus.Funct3 = '0;
        bus.Operand1 = '0; bus.Operand2 = '0; bus.DestAddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'b0, bus.Busy}, 32'd0);
        check_eq("rst_done", {31'b0, bus.Done}, 32'd0);
        check_eq("rst_wdata", bus.WriteData, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed results with fixed expectations
        issue("mul7", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, 33);
        check_eq("mul7_busy", {31'b0, bus.Busy}, 32'd1);
        drain("mul7");
        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);
        run("mul_ovf",3'b000, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0000_0000, 33);
        run("div_n7", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
        run("rem_n7", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
        run("divu",   3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 33);
        run("remu",   3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 33);
        run("div_7n", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
        run("rem_7n", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1, 33);

        // Fast path: Done on the second edge after accept
        run("div0",   3'b100, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        run("remu0",  3'b111, 32'd5, 32'd0, 5'd13, 32'd5, 1);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);

        // rd=0 still completes but must not write
        run("rd0", 3'b000, 32'd9, 32'd9, 5'd0, 32'd81, 33);

        // Start while busy is ignored; original operands are used
        issue("ign", 3'b000, 32'd3, 32'd5, 5'd16, 1'b1, 32'd15, 33);
        repeat (5) @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = 3'b101; bus.Operand1 = 32'd1000;
        bus.Operand2 = 32'd3; bus.DestAddr = 5'd17;
        @(negedge clk);
        bus.Start = 1'b0;
        drain("ign");

        // Kill mid-CALC: unit frees up and never completes
        issue("kill", 3'b101, 32'd100, 32'd7, 5'd18, 1'b0, 32'd0, 0);
        repeat (9) @(negedge clk);
        bus.Kill = 1'b1;
        @(negedge clk);
        bus.Kill = 1'b0;
        check_eq("kill_busy", {31'b0, bus.Busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Kill and Start together in IDLE: nothing accepted
        bus.Kill = 1'b1; bus.Start = 1'b1; bus.Funct3 = 3'b000;
        bus.Operand1 = 32'd2; bus.Operand2 = 32'd2; bus.DestAddr = 5'd19;
        @(negedge clk);
        bus.Kill = 1'b0; bus.Start = 1'b0;
        check_eq("killstart_busy", {31'b0, bus.Busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Reset mid-CALC clears outputs and drops the op
        issue("rstmid", 3'b000, 32'd6, 32'd7, 5'd20, 1'b0, 32'd0, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rstmid_busy", {31'b0, bus.Busy}, 32'd0);
        check_eq("rstmid_done", {31'b0, bus.Done}, 32'd0);
        check_eq("rstmid_rw", {31'b0, bus.RegWrite}, 32'd0);
        check_eq("rstmid_waddr", {27'b0, bus.WriteAddr}, 32'd0);
        check_eq("rstmid_wdata", bus.WriteData, 32'd0);
        repeat (40) @(negedge clk);
        run("mul34", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33);

        // Random operations against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int unsigned lat;
            f3 = 3'($urandom);
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rd = 5'($urandom);
            lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
            run($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, rd, model(f3, a, b), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
